// File: rtl/hold_gen.sv
// hold_gen: programmable pulse-train generator.
// After an accepted start it waits delay_len cycles, then emits repeat_n
// high pulses of hold_len cycles separated by gap_len low cycles.
// Zero lengths for hold/gap/repeat behave as 1; a zero delay goes straight
// to the first high cycle.
//
// Ports:
//   rstn      - asynchronous active-low reset
//   clk       - clock, rising edge
//   start     - begin a train (sampled only while idle)
//   abort     - synchronous cancel; wins over start
//   delay_len - cycles between acceptance latency and first high cycle
//   hold_len  - high cycles per pulse
//   gap_len   - low cycles between pulses
//   repeat_n  - pulses per train
//   out       - registered output level
//   busy      - train in progress
//   done      - one-cycle pulse on normal completion
module hold_gen #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             rstn,
  input  logic             clk,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] delay_len,
  input  logic [CNT_W-1:0] hold_len,
  input  logic [CNT_W-1:0] gap_len,
  input  logic [7:0]       repeat_n,
  output logic             out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, DELAY, HOLD, GAP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       rep_cnt, rep_n;
  logic [CNT_W-1:0] lat_delay, lat_delay_n;
  logic [CNT_W-1:0] lat_hold, lat_hold_n;
  logic [CNT_W-1:0] lat_gap, lat_gap_n;
  logic             out_n, done_n;

  // Counters hold "cycles remaining minus one", so a length of 0 or 1 both
  // give a single cycle and the maximum length still fits without wrapping.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      rep_cnt   <= '0;
      lat_delay <= '0;
      lat_hold  <= '0;
      lat_gap   <= '0;
      out       <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rep_cnt   <= rep_n;
      lat_delay <= lat_delay_n;
      lat_hold  <= lat_hold_n;
      lat_gap   <= lat_gap_n;
      out       <= out_n;
      done      <= done_n;
    end
  end

  assign busy = (state != IDLE);

  // out/done are computed from the next state so they are registered yet
  // aligned with the state they describe.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    rep_n       = rep_cnt;
    lat_delay_n = lat_delay;
    lat_hold_n  = lat_hold;
    lat_gap_n   = lat_gap;
    out_n       = 1'b0;
    done_n      = 1'b0;
    if (abort) begin
      state_n = IDLE;
      cnt_n   = '0;
      rep_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            lat_delay_n = delay_len;
            lat_hold_n  = hold_len;
            lat_gap_n   = gap_len;
            rep_n       = (repeat_n == '0) ? '0 : repeat_n - 8'd1;
            if (delay_len != '0) begin
              state_n = DELAY;
              cnt_n   = delay_len - 1'b1;
            end else begin
              state_n = HOLD;
              cnt_n   = len_m1(hold_len);
              out_n   = 1'b1;
            end
          end
        end
        DELAY, GAP: begin
          if (cnt == '0) begin
            state_n = HOLD;
            cnt_n   = len_m1(lat_hold);
            out_n   = 1'b1;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            if (rep_cnt == '0) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = GAP;
              cnt_n   = len_m1(lat_gap);
              rep_n   = rep_cnt - 8'd1;
            end
          end else begin
            cnt_n = cnt - 1'b1;
            out_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: doc/hold_gen.md
HOLD_GEN -- requirements
Module: hold_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the delay/hold/gap counters and length inputs.
REQ-002 The block SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port start  input  1  one-cycle request to begin a pulse train; sampled only in IDLE.
REQ-005 The block SHALL have port abort  input  1  synchronous cancel of any train in progress.
REQ-006 The block SHALL have port delay_len  input  CNT_W  cycles from accepted start to first high cycle, excluding the one-cycle latch latency.
REQ-007 The block SHALL have port hold_len  input  CNT_W  high duration per pulse in cycles; 0 treated as 1.
REQ-008 The block SHALL have port gap_len  input  CNT_W  low duration between pulses in cycles; 0 treated as 1.
REQ-009 The block SHALL have port repeat_n  input  8  number of pulses in the train; 0 treated as 1.
REQ-010 The block SHALL have port out  output  1  registered generated level.
REQ-011 The block SHALL have port busy  output  1  high while a train is in progress (any state other than IDLE).
REQ-012 The block SHALL have port done  output  1  one-cycle pulse on normal train completion.

Function
REQ-013 The FSM SHALL have states IDLE, DELAY, HOLD, GAP.
REQ-014 In IDLE, start=1 at edge T SHALL latch delay_len, hold_len, gap_len and repeat_n, and SHALL set busy=1 from T+1.
REQ-015 At T, the next state SHALL be DELAY if delay_len>0, otherwise HOLD.
REQ-016 Input changes after acceptance SHALL NOT affect the running train.
REQ-017 The first out=1 cycle SHALL be cycle T+1+delay_len.
REQ-018 out SHALL be 1 exactly in HOLD, for exactly max(hold_len,1) consecutive cycles per pulse.
REQ-019 After each pulse except the last, the FSM SHALL enter GAP with out=0 for exactly max(gap_len,1) cycles, then return to HOLD.
REQ-020 After the last pulse, done=1 and busy=0 SHALL both occur in the cycle immediately following the final high cycle, with the FSM in IDLE.
REQ-021 A start accepted in the same cycle that done=1 SHALL begin a new train with no extra idle cycle.
REQ-022 start while busy=1 SHALL be ignored; it SHALL NOT be queued.
REQ-023 abort=1 at any edge SHALL force IDLE, with out=0, busy=0 and done=0 in the next cycle; no done pulse SHALL be issued for an aborted train.
REQ-024 When start and abort are both 1 in IDLE, abort SHALL win and the start SHALL NOT be accepted.
REQ-025 Counters SHALL count down and SHALL reload on each state entry; they SHALL never wrap.
REQ-026 Maximum lengths SHALL be 2^CNT_W-1 cycles with no overflow.
REQ-027 A pulse of hold_len=N+1 SHALL satisfy a downstream level-hold detector configured with delay N; this is the intended pairing with the team's hold detector.

Reset
REQ-028 While rstn=0, the FSM SHALL be in IDLE with out=0, busy=0, done=0, all counters 0 and all latched lengths 0.
REQ-029 Reset asserted mid-train SHALL drop out to 0 immediately (asynchronously); no done pulse SHALL follow.
REQ-030 After reset release, the block SHALL accept start on the first clock edge.

Verification
REQ-031 delay=3, hold=5, gap=x, repeat=1, start at cycle 0 -> out=1 in cycles 4..8, done=1 and busy=0 in cycle 9.
REQ-032 delay=0, hold=2, gap=3, repeat=3, start at cycle 0 -> out=1 in cycles 1-2, 6-7 and 11-12; done at cycle 13.
REQ-033 hold=0, gap=0, repeat=0, delay=0 -> exactly one single-cycle high pulse at cycle 1, done at cycle 2.
REQ-034 Start pulses during a busy train plus a start coincident with done -> mid-train starts ignored; the coincident start produces a back-to-back train.
REQ-035 abort asserted in HOLD cycle 2 of 5 -> out=0 and busy=0 next cycle, no done; the same test repeated with rstn pulled low mid-GAP -> all outputs 0 asynchronously.
REQ-036 hold=101, delay=0, driving a hold detector with delay 100 -> the detector emits exactly one pulse; with hold=100 -> no detector pulse.
